// File: rtl/dc_mem_resp_pkg.sv
// Shared types and constants for the cache-line memory responder.
package dc_mem_resp_pkg;

    localparam int          LINE_BYTES = 16;
    localparam logic [15:0] FULL_MASK  = 16'hFFFF;
    localparam int          CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT,
        RD_BEAT,
        RD_FIN
    } state_e;

    typedef enum logic [1:0] {
        CH_DCW,
        CH_DCR,
        CH_ICR
    } ch_e;

endpackage

// File: rtl/line_ram_be.sv
// 128-bit line RAM: byte-enable write port, registered 1-cycle read port.
module line_ram_be
    import dc_mem_resp_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  logic [15:0]   be,
    input  logic [127:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] rd_idx,
    output logic [127:0]  rdata
);

    logic [127:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (we && be[i]) begin
                mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/dc_mem_responder.sv
// Memory-side responder for dcache write/read and icache read channels.
// Optional DC_MEM_ADDR_CHECK_EN adds a sticky addr_err for out-of-range addresses.
module dc_mem_responder
    import dc_mem_resp_pkg::*;
#(
    parameter int MWIDTH = 12,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dcw_start_rq,
    input  logic [31:0]  dcw_in_addr,
    input  logic [15:0]  dcw_in_mask,
    input  logic [127:0] dcw_in_data,
    output logic         dcw_finish_wresp,
    input  logic         dcr_start_rq,
    input  logic [31:0]  dcr_rin_addr,
    output logic [127:0] rdat_m_data,
    output logic         rdat_m_valid,
    output logic         finish_mrd,
    input  logic         icr_start_rq,
    input  logic [31:0]  ic_rin_addr,
    output logic [127:0] ic_rdat_m_data,
    output logic [15:0]  ic_rdat_m_mask,
    output logic         ic_rdat_m_valid,
    output logic         ic_finish_mrd,
    output logic         resp_busy
`ifdef DC_MEM_ADDR_CHECK_EN
    ,
    output logic         addr_err
`endif
);

    state_e             state, state_nx;
    ch_e                cur_ch;
    logic [CNT_W-1:0]   cnt;
    logic               wresp_q;
    logic               dcw_pend, dcr_pend, icr_pend;
    logic [31:0]        dcw_addr_q, dcr_addr_q, icr_addr_q;
    logic [15:0]        dcw_mask_q;
    logic [127:0]       dcw_data_q;
    logic [31:0]        dcw_addr, dcr_addr, icr_addr, rd_addr;
    logic [15:0]        dcw_mask;
    logic [127:0]       dcw_data;
    logic               dcw_req, dcr_req, icr_req;
    logic               gnt_wr, gnt_dcr, gnt_icr, pref_icr;
    logic [MWIDTH-1:0]  cur_idx;
    logic [127:0]       ram_q, beat_data, dcr_hold, ic_hold;
    logic               ram_we, ram_re;
    logic               unused_bits;

    // A request is live either from its latch or from a same-cycle pulse.
    assign dcw_req  = dcw_pend | dcw_start_rq;
    assign dcr_req  = dcr_pend | dcr_start_rq;
    assign icr_req  = icr_pend | icr_start_rq;
    assign dcw_addr = dcw_pend ? dcw_addr_q : dcw_in_addr;
    assign dcw_mask = dcw_pend ? dcw_mask_q : dcw_in_mask;
    assign dcw_data = dcw_pend ? dcw_data_q : dcw_in_data;
    assign dcr_addr = dcr_pend ? dcr_addr_q : dcr_rin_addr;
    assign icr_addr = icr_pend ? icr_addr_q : ic_rin_addr;

    assign gnt_wr  = (state == IDLE) && dcw_req;
    assign gnt_dcr = (state == IDLE) && !dcw_req && dcr_req
                     && (!icr_req || !pref_icr);
    assign gnt_icr = (state == IDLE) && !dcw_req && icr_req
                     && (!dcr_req || pref_icr);
    assign rd_addr = gnt_dcr ? dcr_addr : icr_addr;
    assign ram_re  = (state == RD_WAIT) && (cnt == '0);

    assign unused_bits = ^{dcw_addr[31:MWIDTH+4], dcw_addr[3:0],
                           rd_addr[31:MWIDTH+4], rd_addr[3:0]};

`ifdef DC_MEM_ADDR_CHECK_EN
    logic rd_oor;

    function automatic logic hi_bad(input logic [31:0] a);
        return |a[31:MWIDTH+4];
    endfunction

    assign ram_we    = gnt_wr && !hi_bad(dcw_addr);
    assign beat_data = rd_oor ? '0 : ram_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_oor   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (gnt_dcr || gnt_icr) rd_oor <= hi_bad(rd_addr);
            addr_err <= addr_err
                      | (dcw_start_rq && hi_bad(dcw_in_addr))
                      | (dcr_start_rq && hi_bad(dcr_rin_addr))
                      | (icr_start_rq && hi_bad(ic_rin_addr));
        end
    end
`else
    assign ram_we    = gnt_wr;
    assign beat_data = ram_q;
`endif

    line_ram_be #(.AW(MWIDTH)) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .wr_idx (dcw_addr[MWIDTH+3:4]),
        .be     (dcw_mask),
        .wdata  (dcw_data),
        .re     (ram_re),
        .rd_idx (cur_idx),
        .rdata  (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (dcw_req)                state_nx = WR_WAIT;
                else if (dcr_req | icr_req) state_nx = RD_WAIT;
            end
            WR_WAIT: if (wresp_q) state_nx = IDLE;
            RD_WAIT: if (cnt == '0) state_nx = RD_BEAT;
            RD_BEAT: state_nx = RD_FIN;
            RD_FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            wresp_q    <= 1'b0;
            dcw_pend   <= 1'b0;
            dcr_pend   <= 1'b0;
            icr_pend   <= 1'b0;
            dcw_addr_q <= '0;
            dcw_mask_q <= '0;
            dcw_data_q <= '0;
            dcr_addr_q <= '0;
            icr_addr_q <= '0;
            cur_ch     <= CH_DCR;
            cur_idx    <= '0;
            pref_icr   <= 1'b0;
            dcr_hold   <= '0;
            ic_hold    <= '0;
        end else begin
            if (gnt_wr)                  cnt <= CNT_W'(WR_LAT - 2);
            else if (gnt_dcr || gnt_icr) cnt <= CNT_W'(RD_LAT - 2);
            else if (cnt != '0)          cnt <= cnt - 1'b1;

            // wresp is held in WR_WAIT for its pulse cycle, then IDLE.
            wresp_q <= (state == WR_WAIT) && (cnt == '0) && !wresp_q;

            if (dcw_start_rq && !dcw_pend) begin
                dcw_pend   <= 1'b1;
                dcw_addr_q <= dcw_in_addr;
                dcw_mask_q <= dcw_in_mask;
                dcw_data_q <= dcw_in_data;
            end
            if (dcr_start_rq && !dcr_pend) begin
                dcr_pend   <= 1'b1;
                dcr_addr_q <= dcr_rin_addr;
            end
            if (icr_start_rq && !icr_pend) begin
                icr_pend   <= 1'b1;
                icr_addr_q <= ic_rin_addr;
            end

            if (wresp_q) dcw_pend <= 1'b0;
            if (state == RD_BEAT) begin
                if (cur_ch == CH_DCR) begin
                    dcr_pend <= 1'b0;
                    dcr_hold <= beat_data;
                end else begin
                    icr_pend <= 1'b0;
                    ic_hold  <= beat_data;
                end
            end

            if (gnt_dcr || gnt_icr) begin
                cur_ch   <= gnt_dcr ? CH_DCR : CH_ICR;
                cur_idx  <= rd_addr[MWIDTH+3:4];
                pref_icr <= gnt_dcr;
            end
        end
    end

    always_comb begin
        dcw_finish_wresp = wresp_q;
        rdat_m_valid     = (state == RD_BEAT) && (cur_ch == CH_DCR);
        ic_rdat_m_valid  = (state == RD_BEAT) && (cur_ch == CH_ICR);
        finish_mrd       = (state == RD_FIN) && (cur_ch == CH_DCR);
        ic_finish_mrd    = (state == RD_FIN) && (cur_ch == CH_ICR);
        rdat_m_data      = rdat_m_valid ? beat_data : dcr_hold;
        ic_rdat_m_data   = ic_rdat_m_valid ? beat_data : ic_hold;
        ic_rdat_m_mask   = ic_rdat_m_valid ? FULL_MASK : 16'h0;
        resp_busy        = dcw_pend | dcr_pend | icr_pend | (state != IDLE);
    end

endmodule

// File: tb/tb_dc_mem_responder.sv
// Randomised self-checking bench for dc_mem_responder against a line-array model.
// Define DC_MEM_ADDR_CHECK_EN to also exercise addr_err.
module tb_dc_mem_responder;

    localparam int MW     = 12;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         dcw_start_rq, dcr_start_rq, icr_start_rq;
    logic [31:0]  dcw_in_addr, dcr_rin_addr, ic_rin_addr;
    logic [15:0]  dcw_in_mask;
    logic [127:0] dcw_in_data;
    logic         dcw_finish_wresp;
    logic [127:0] rdat_m_data, ic_rdat_m_data;
    logic         rdat_m_valid, finish_mrd;
    logic [15:0]  ic_rdat_m_mask;
    logic         ic_rdat_m_valid, ic_finish_mrd;
    logic         resp_busy;
`ifdef DC_MEM_ADDR_CHECK_EN
    logic         addr_err;
`endif

    dc_mem_responder #(.MWIDTH(MW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .dcw_start_rq     (dcw_start_rq),
        .dcw_in_addr      (dcw_in_addr),
        .dcw_in_mask      (dcw_in_mask),
        .dcw_in_data      (dcw_in_data),
        .dcw_finish_wresp (dcw_finish_wresp),
        .dcr_start_rq     (dcr_start_rq),
        .dcr_rin_addr     (dcr_rin_addr),
        .rdat_m_data      (rdat_m_data),
        .rdat_m_valid     (rdat_m_valid),
        .finish_mrd       (finish_mrd),
        .icr_start_rq     (icr_start_rq),
        .ic_rin_addr      (ic_rin_addr),
        .ic_rdat_m_data   (ic_rdat_m_data),
        .ic_rdat_m_mask   (ic_rdat_m_mask),
        .ic_rdat_m_valid  (ic_rdat_m_valid),
        .ic_finish_mrd    (ic_finish_mrd),
        .resp_busy        (resp_busy)
`ifdef DC_MEM_ADDR_CHECK_EN
        ,
        .addr_err         (addr_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, filled away from the active edge.
    int           wr_q[$], dv_q[$], fin_q[$], iv_q[$], ifin_q[$], beat_q[$];
    logic [127:0] dvd_q[$], ivd_q[$];
    int           busy_last = 0;
    int           mask_bad = 0;

    always @(negedge clk) begin
        if (dcw_finish_wresp) wr_q.push_back(cyc);
        if (rdat_m_valid) begin
            dv_q.push_back(cyc);
            dvd_q.push_back(rdat_m_data);
            beat_q.push_back(1);
        end
        if (finish_mrd) fin_q.push_back(cyc);
        if (ic_rdat_m_valid) begin
            iv_q.push_back(cyc);
            ivd_q.push_back(ic_rdat_m_data);
            beat_q.push_back(2);
            if (ic_rdat_m_mask !== 16'hFFFF) mask_bad++;
        end else if (ic_rdat_m_mask !== 16'h0) begin
            mask_bad++;
        end
        if (ic_finish_mrd) ifin_q.push_back(cyc);
        if (resp_busy) busy_last = cyc;
    end

    // Reference memory: one 128-bit value per line index.
    logic [127:0] mem [int];

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete(); dv_q.delete(); fin_q.delete();
        iv_q.delete(); ifin_q.delete(); beat_q.delete();
        dvd_q.delete(); ivd_q.delete();
    endtask

    task automatic wait_quiet();
        int n = 0;
        step();
        while (resp_busy && n < 300) begin
            step();
            n++;
        end
        chk("quiet_timeout", resp_busy, 0);
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) & ((32'd1 << MW) - 1));
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] old,
                                           input logic [15:0] m,
                                           input logic [127:0] d);
        logic [127:0] r = old;
        for (int i = 0; i < 16; i++)
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mk_addr(input int idx);
        logic [31:0] a = $urandom;
        logic [31:0] iv = idx;
        a[MW+3:4] = iv[MW-1:0];
`ifdef DC_MEM_ADDR_CHECK_EN
        a[31:MW+4] = '0;
`endif
        return a;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [15:0] m,
                            input logic [127:0] d, input bit commit);
        int c0;
        clear_logs();
        dcw_in_addr = a; dcw_in_mask = m; dcw_in_data = d;
        dcw_start_rq = 1'b1;
        c0 = cyc;
        step();
        dcw_start_rq = 1'b0;
        wait_quiet();
        chk("wr_count", wr_q.size(), 1);
        if (wr_q.size() > 0) chk("wr_lat", wr_q[0] - c0, WR_LAT);
        if (commit) begin
            if (m == 16'hFFFF) mem[line_of(a)] = d;
            else mem[line_of(a)] = merge(mem[line_of(a)], m, d);
        end
    endtask

    task automatic do_read(input bit ic, input logic [31:0] a,
                           input logic [127:0] exp);
        int c0;
        clear_logs();
        if (ic) begin ic_rin_addr = a; icr_start_rq = 1'b1; end
        else begin dcr_rin_addr = a; dcr_start_rq = 1'b1; end
        c0 = cyc;
        step();
        dcr_start_rq = 1'b0;
        icr_start_rq = 1'b0;
        wait_quiet();
        if (!ic) begin
            chk("dcr_beats", dv_q.size(), 1);
            chk("dcr_ic_beats", iv_q.size(), 0);
            if (dv_q.size() > 0) begin
                chk("dcr_lat", dv_q[0] - c0, RD_LAT);
                chk("dcr_data", dvd_q[0], exp);
            end
            if (fin_q.size() > 0) chk("dcr_fin_lat", fin_q[0] - c0, RD_LAT + 1);
            else chk("dcr_fin_count", 0, 1);
            chk("dcr_hold", rdat_m_data, exp);
        end else begin
            chk("icr_beats", iv_q.size(), 1);
            chk("icr_dc_beats", dv_q.size(), 0);
            if (iv_q.size() > 0) begin
                chk("icr_lat", iv_q[0] - c0, RD_LAT);
                chk("icr_data", ivd_q[0], exp);
            end
            if (ifin_q.size() > 0) chk("icr_fin_lat", ifin_q[0] - c0, RD_LAT + 1);
            else chk("icr_fin_count", 0, 1);
            chk("icr_hold", ic_rdat_m_data, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wresp"}, dcw_finish_wresp, 0);
        chk({tag, "_dv"}, rdat_m_valid, 0);
        chk({tag, "_fin"}, finish_mrd, 0);
        chk({tag, "_ddata"}, rdat_m_data, 0);
        chk({tag, "_iv"}, ic_rdat_m_valid, 0);
        chk({tag, "_ifin"}, ic_finish_mrd, 0);
        chk({tag, "_idata"}, ic_rdat_m_data, 0);
        chk({tag, "_imask"}, ic_rdat_m_mask, 0);
        chk({tag, "_busy"}, resp_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d, d55, da;
        logic [31:0]  a;
        int           lines[8];
        int           exp_wr, exp_dv, exp_fin, exp_iv, exp_ifin;
        int           viol, ndcr, nicr;

        rst = 1'b1;
        dcw_start_rq = 0; dcr_start_rq = 0; icr_start_rq = 0;
        dcw_in_addr = 0; dcw_in_mask = 0; dcw_in_data = 0;
        dcr_rin_addr = 0; ic_rin_addr = 0;
        repeat (3) step();
        chk_outputs_zero("reset");
`ifdef DC_MEM_ADDR_CHECK_EN
        chk("reset_addr_err", addr_err, 0);
`endif
        rst = 1'b0;
        step();

        // Full-mask write then read of line 0x40.
        d = 128'h00112233445566778899AABBCCDDEEFF;
        do_write(32'h0000_0040, 16'hFFFF, d, 1);
        do_read(0, 32'h0000_0040, mem[line_of(32'h40)]);
        chk("full_rd", rdat_m_data, d);

        // Partial mask over a line of 0x55.
        d55 = {16{8'h55}};
        do_write(32'h0000_0080, 16'hFFFF, d55, 1);
        do_write(32'h0000_0080, 16'h000F, {96'h0, 32'hAAAA_AAAA}, 1);
        do_read(1, 32'h0000_0080, mem[line_of(32'h80)]);
        chk("pm_w0", ic_rdat_m_data[31:0], 32'hAAAA_AAAA);
        chk("pm_w1", ic_rdat_m_data[63:32], 32'h5555_5555);
        chk("pm_w2", ic_rdat_m_data[95:64], 32'h5555_5555);
        chk("pm_w3", ic_rdat_m_data[127:96], 32'h5555_5555);

        // All three channels pulsed together.
        do_write(32'h0000_0200, 16'hFFFF, rnd128(), 1);
        da = rnd128();
        clear_logs();
        dcw_in_addr = 32'h0000_0100; dcw_in_mask = 16'hFFFF; dcw_in_data = da;
        dcr_rin_addr = 32'h0000_0100;
        ic_rin_addr = 32'h0000_0200;
        dcw_start_rq = 1; dcr_start_rq = 1; icr_start_rq = 1;
        exp_wr = cyc + WR_LAT;
        step();
        dcw_start_rq = 0; dcr_start_rq = 0; icr_start_rq = 0;
        wait_quiet();
        mem[line_of(32'h100)] = da;
        exp_dv = exp_wr + 1 + RD_LAT;
        exp_fin = exp_dv + 1;
        exp_iv = exp_fin + 1 + RD_LAT;
        exp_ifin = exp_iv + 1;
        chk("ct_wr_n", wr_q.size(), 1);
        chk("ct_dv_n", dv_q.size(), 1);
        chk("ct_iv_n", iv_q.size(), 1);
        if (wr_q.size() > 0) chk("ct_wr_cyc", wr_q[0], exp_wr);
        if (dv_q.size() > 0) begin
            chk("ct_dv_cyc", dv_q[0], exp_dv);
            chk("ct_dv_data", dvd_q[0], da);
        end
        if (fin_q.size() > 0) chk("ct_fin_cyc", fin_q[0], exp_fin);
        if (iv_q.size() > 0) begin
            chk("ct_iv_cyc", iv_q[0], exp_iv);
            chk("ct_iv_data", ivd_q[0], mem[line_of(32'h200)]);
        end
        if (ifin_q.size() > 0) chk("ct_ifin_cyc", ifin_q[0], exp_ifin);
        chk("ct_busy_last", busy_last, exp_ifin);

        // Fairness: both read channels re-pulsed every cycle.
        clear_logs();
        dcr_rin_addr = 32'h0000_0100;
        ic_rin_addr = 32'h0000_0200;
        repeat (36) begin
            dcr_start_rq = 1; icr_start_rq = 1;
            step();
        end
        dcr_start_rq = 0; icr_start_rq = 0;
        wait_quiet();
        viol = 0; ndcr = 0; nicr = 0;
        foreach (beat_q[i]) begin
            if (beat_q[i] == 1) ndcr++; else nicr++;
            if (i > 0 && beat_q[i] == beat_q[i-1]) viol++;
        end
        chk("fair_alternate", viol, 0);
        chk("fair_dcr_served", ndcr >= 3, 1);
        chk("fair_icr_served", nicr >= 3, 1);
        foreach (dvd_q[i]) chk("fair_dcr_data", dvd_q[i], mem[line_of(32'h100)]);
        foreach (ivd_q[i]) chk("fair_icr_data", ivd_q[i], mem[line_of(32'h200)]);

        // Reset while the read is waiting.
        do_write(32'h0000_0300, 16'hFFFF, rnd128(), 1);
        clear_logs();
        dcr_rin_addr = 32'h0000_0300;
        dcr_start_rq = 1;
        step();
        dcr_start_rq = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        repeat (8) step();
        chk("rst_no_dv", dv_q.size(), 0);
        chk("rst_no_fin", fin_q.size(), 0);
        chk_outputs_zero("rst_mid");
        do_read(0, 32'h0000_0300, mem[line_of(32'h300)]);

        // Randomised single transactions over a handful of lines.
        for (int i = 0; i < 8; i++) begin
            lines[i] = i * 37 + 5;
            do_write(mk_addr(lines[i]), 16'hFFFF, rnd128(), 1);
        end
        for (int n = 0; n < 80; n++) begin
            a = mk_addr(lines[$urandom_range(0, 7)]);
            case ($urandom_range(0, 2))
                0: do_write(a, 16'($urandom), rnd128(), 1);
                1: do_read(0, a, mem[line_of(a)]);
                default: do_read(1, a, mem[line_of(a)]);
            endcase
        end

`ifdef DC_MEM_ADDR_CHECK_EN
        chk("ae_clear", addr_err, 0);
        do_read(0, 32'h8000_0000, 128'h0);
        chk("ae_set", addr_err, 1);
        do_write(32'h8000_0040, 16'hFFFF, rnd128(), 0);
        do_read(1, 32'h0000_0040, mem[line_of(32'h40)]);
        chk("ae_sticky", addr_err, 1);
        rst = 1;
        step();
        rst = 0;
        step();
        chk("ae_rst", addr_err, 0);
`endif

        chk("ic_mask_idle", mask_bad, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
